// File: rtl/dac_segment_encoder_if.sv
// Code handshake bundle between the code source and dac_segment_encoder.
// The master drives code_in/code_valid; the encoder (slave) drives code_ready.
interface dac_segment_encoder_if #(
    parameter int CODE_W = 12
) ();
    logic [CODE_W-1:0] code_in;
    logic              code_valid;
    logic              code_ready;

    modport master (
        output code_in,
        output code_valid,
        input  code_ready
    );

    modport slave (
        input  code_in,
        input  code_valid,
        output code_ready
    );
endinterface

// File: rtl/dac_segment_encoder.sv
// dac_segment_encoder: converts an unsigned DAC code into the segmented driver-cell
// control word (BIN_W binary LSBs + THERM_W unary elements, each with its complement)
// and sequences the driver-cell power-down line through OFF -> WARMUP -> ACTIVE.
//
// Optional build macro: DWA_ROTATE_EN
//   defined   - data-weighted averaging: unary elements are taken starting at a
//               rotating pointer so every element sees the same average usage.
//   undefined - plain thermometer filled from bit 0 upward.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_OFF  | pdb low, zero code, no codes accepted
// ST_WARM | pdb high, driver cell settling, zero code held
// ST_ACT  | pdb high, codes accepted, outputs follow accepted code
module dac_segment_encoder #(
    parameter int BIN_W      = 7,
    parameter int THERM_W    = 17,
    parameter int CODE_W     = 12,
    parameter int WARMUP_CYC = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    dac_segment_encoder_if.slave bus,
    output logic [BIN_W-1:0]   datain,
    output logic [BIN_W-1:0]   datainb,
    output logic [THERM_W-1:0] datatherm,
    output logic [THERM_W-1:0] datathermb,
    output logic               pdb,
    output logic               sat_flag
);

    localparam int MAX_CODE = THERM_W * (2 ** BIN_W) + (2 ** BIN_W) - 1;
    localparam int N_W      = $clog2(THERM_W + 1);
    localparam int CNT_W    = $clog2(WARMUP_CYC + 1);

    localparam logic [CODE_W-1:0] MAX_CODE_C = CODE_W'(MAX_CODE);
    localparam logic [CNT_W-1:0]  WARM_LAST  = CNT_W'(WARMUP_CYC - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WARM = 2'd1,
        ST_ACT  = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  warm_cnt;
    logic              ready_q;

    logic              accept;
    logic              code_sat;
    logic [CODE_W-1:0] code_clamped;
    logic [N_W-1:0]    n_next;
    logic [BIN_W-1:0]  lsb_next;
    logic [THERM_W-1:0] therm_next;

`ifdef DWA_ROTATE_EN
    localparam int PTR_W = (THERM_W > 1) ? $clog2(THERM_W) : 1;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_next;
`endif

    // The registered ready is gated by enable so a code offered in the cycle enable
    // falls never completes a handshake.
    assign bus.code_ready = ready_q & enable;
    assign accept         = bus.code_valid & bus.code_ready;

    // Clamp to the largest representable segmented code and split into fields.
    always_comb begin
        code_sat     = (bus.code_in > MAX_CODE_C);
        code_clamped = code_sat ? MAX_CODE_C : bus.code_in;
        n_next       = N_W'(code_clamped >> BIN_W);
        lsb_next     = code_clamped[BIN_W-1:0];
    end

`ifdef DWA_ROTATE_EN
    // Rotated thermometer: elements ptr .. ptr+n-1 (mod THERM_W) are on.
    always_comb begin
        int sum;
        therm_next = '0;
        for (int i = 0; i < THERM_W; i++) begin
            therm_next[i] = (((i - int'(ptr) + THERM_W) % THERM_W) < int'(n_next));
        end
        sum = int'(ptr) + int'(n_next);
        if (sum >= THERM_W) begin
            sum = sum - THERM_W;
        end
        ptr_next = PTR_W'(sum);
    end
`else
    // Plain thermometer: elements 0 .. n-1 are on.
    always_comb begin
        therm_next = '0;
        for (int i = 0; i < THERM_W; i++) begin
            therm_next[i] = (i < int'(n_next));
        end
    end
`endif

    // Power sequencing FSM with registered driver-cell outputs.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            state      <= ST_OFF;
            warm_cnt   <= '0;
            ready_q    <= 1'b0;
            pdb        <= 1'b0;
            sat_flag   <= 1'b0;
            datain     <= '0;
            datainb    <= '1;
            datatherm  <= '0;
            datathermb <= '1;
`ifdef DWA_ROTATE_EN
            ptr        <= '0;
`endif
        end else begin
            case (state)
                ST_OFF: begin
                    state    <= ST_WARM;
                    pdb      <= 1'b1;
                    warm_cnt <= '0;
                end
                ST_WARM: begin
                    if (warm_cnt == WARM_LAST) begin
                        state   <= ST_ACT;
                        ready_q <= 1'b1;
                    end else begin
                        warm_cnt <= warm_cnt + 1'b1;
                    end
                end
                ST_ACT: begin
                    sat_flag <= 1'b0;
                    if (accept) begin
                        datain     <= lsb_next;
                        datainb    <= ~lsb_next;
                        datatherm  <= therm_next;
                        datathermb <= ~therm_next;
                        sat_flag   <= code_sat;
`ifdef DWA_ROTATE_EN
                        ptr        <= ptr_next;
`endif
                    end
                end
                default: begin
                    state   <= ST_OFF;
                    pdb     <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_segment_encoder.sv
// Self-checking bench for dac_segment_encoder: directed reset/warmup checks, a table
// of code vectors, enable-drop and mid-operation reset sequences, and a randomized
// run compared every cycle against a cycle-level behavioural model.
module tb_dac_segment_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [6:0]  datain, datainb;
    logic [16:0] datatherm, datathermb;
    logic        pdb, sat_flag;

    int checks = 0;
    int errors = 0;

    dac_segment_encoder_if #(.CODE_W(12)) bus ();

    dac_segment_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .bus        (bus),
        .datain     (datain),
        .datainb    (datainb),
        .datatherm  (datatherm),
        .datathermb (datathermb),
        .pdb        (pdb),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;

    // Behavioural model state (expected outputs after the next edge)
    int m_pdb = 0, m_ready = 0, m_since = 0, m_code = 0, m_sat = 0, m_ptr = 0, m_therm = 0;

    function automatic int therm_of(input int n, input int p);
        int t;
        t = 0;
        for (int k = 0; k < n; k++) begin
`ifdef DWA_ROTATE_EN
            t = t | (1 << ((p + k) % 17));
`else
            t = t | (1 << k);
`endif
        end
        return t;
    endfunction

    task automatic model_step(input logic r, input logic e, input logic v, input int c);
        int cc, n;
        if (r || !e) begin
            m_pdb = 0; m_ready = 0; m_since = 0; m_code = 0;
            m_sat = 0; m_ptr = 0; m_therm = 0;
        end else if (m_pdb == 0) begin
            m_pdb   = 1;
            m_since = 0;
        end else if (m_ready == 0) begin
            m_since = m_since + 1;
            if (m_since == 16) m_ready = 1;
        end else begin
            m_sat = 0;
            if (v) begin
                cc      = (c > 2303) ? 2303 : c;
                m_sat   = (c > 2303) ? 1 : 0;
                m_code  = cc;
                n       = cc / 128;
                m_therm = therm_of(n, m_ptr);
                m_ptr   = (m_ptr + n) % 17;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("datain",     32'(datain),     32'(m_code % 128));
        chk("datainb",    32'(datainb),    32'((~(m_code % 128)) & 'h7F));
        chk("datatherm",  32'(datatherm),  32'(m_therm));
        chk("datathermb", 32'(datathermb), 32'((~m_therm) & 'h1FFFF));
        chk("pdb",        32'(pdb),        32'(m_pdb));
        chk("code_ready", 32'(bus.code_ready), 32'(m_ready));
        chk("sat_flag",   32'(sat_flag),   32'(m_sat));
    endtask

    // One clock: drive inputs, advance model, sample #1 after the edge, compare.
    task automatic cyc(input logic r, input logic e, input logic v, input int c);
        rst            = r;
        enable         = e;
        bus.code_valid = v;
        bus.code_in    = 12'(c);
        model_step(r, e, v, c);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    typedef struct {
        logic v;
        int   code;
        int   e_din;
        int   e_therm;
        logic e_sat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int k;
        logic r, e, v;
        int c;

`ifdef DWA_ROTATE_EN
        vecs[0] = '{1'b1, 384,  'h00, 'h00007, 1'b0};
        vecs[1] = '{1'b1, 256,  'h00, 'h00018, 1'b0};
        vecs[2] = '{1'b1, 165,  'h25, 'h00020, 1'b0};
`else
        vecs[0] = '{1'b1, 384,  'h00, 'h00007, 1'b0};
        vecs[1] = '{1'b1, 256,  'h00, 'h00003, 1'b0};
        vecs[2] = '{1'b1, 165,  'h25, 'h00001, 1'b0};
`endif
        vecs[3] = '{1'b1, 2303, 'h7F, 'h1FFFF, 1'b0};
        vecs[4] = '{1'b1, 4095, 'h7F, 'h1FFFF, 1'b1};
        vecs[5] = '{1'b0, 0,    'h7F, 'h1FFFF, 1'b0};
        vecs[6] = '{1'b1, 100,  'h64, 'h00000, 1'b0};

        // Reset state
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        chk("rst_datainb",    32'(datainb),    32'h7F);
        chk("rst_datathermb", 32'(datathermb), 32'h1FFFF);
        chk("rst_pdb",        32'(pdb),        32'h0);

        // Enable: pdb one cycle later, ready WARMUP_CYC cycles after pdb
        cyc(0, 1, 0, 0);
        chk("pdb_rise", 32'(pdb), 32'h1);
        k = 0;
        while (!bus.code_ready && k < 40) begin
            cyc(0, 1, 0, 0);
            k++;
        end
        chk("ready_latency", 32'(k), 32'd16);
        chk("warm_therm_zero", 32'(datatherm), 32'h0);

        // Table vectors
        for (int i = 0; i < 7; i++) begin
            cyc(0, 1, vecs[i].v, vecs[i].code);
            chk($sformatf("vec%0d_din", i),   32'(datain),    32'(vecs[i].e_din));
            chk($sformatf("vec%0d_therm", i), 32'(datatherm), 32'(vecs[i].e_therm));
            chk($sformatf("vec%0d_sat", i),   32'(sat_flag),  32'(vecs[i].e_sat));
        end

        // Code offered while enable falls is dropped
        cyc(0, 0, 1, 1000);
        chk("drop_pdb",   32'(pdb),       32'h0);
        chk("drop_din",   32'(datain),    32'h0);
        chk("drop_therm", 32'(datatherm), 32'h0);

        // Mid-operation reset
        k = 0;
        cyc(0, 1, 0, 0);
        while (!bus.code_ready && k < 40) begin
            cyc(0, 1, 0, 0);
            k++;
        end
        chk("ready_latency2", 32'(k), 32'd16);
        cyc(0, 1, 1, 500);
        cyc(1, 1, 1, 500);
        chk("midrst_pdb",   32'(pdb),             32'h0);
        chk("midrst_ready", 32'(bus.code_ready),  32'h0);
        chk("midrst_din",   32'(datain),          32'h0);

        // Randomized run against the model
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 79) != 0);
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0)
                c = $urandom_range(2200, 4095);
            else
                c = $urandom_range(0, 4095);
            cyc(r, e, v, c);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
